// File: rtl/writeback_unit.sv
// Register-file write-port arbiter: ALU results win, long-latency results
// queue in an in-order FIFO, and a scoreboard tracks outstanding destinations.
module writeback_unit #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_waddr,
  input  logic [31:0] alu_wdata,
  input  logic        ll_issue,
  input  logic [4:0]  ll_issue_rd,
  input  logic        ll_valid,
  output logic        ll_ready,
  input  logic [4:0]  ll_waddr,
  input  logic [31:0] ll_wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic        hazard1,
  output logic        hazard2,
  output logic        fwd1,
  output logic        fwd2,
  output logic [31:0] fwd_data1,
  output logic [31:0] fwd_data2,
  output logic        wren,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]   rd_ptr;
  logic [AW:0]   wr_ptr;
  logic [4:0]    fifo_addr [FIFO_DEPTH];
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic          src_ll;
  logic [31:0]   pending;

  logic          empty;
  logic          full;
  logic          alu_sel;
  logic          ll_acc;
  logic          pop;
  logic          direct;
  logic          push;

  logic          wren_d;
  logic [4:0]    waddr_d;
  logic [31:0]   wdata_d;
  logic          src_d;
  logic [31:0]   pending_d;

  assign empty   = (rd_ptr == wr_ptr);
  assign full    = (rd_ptr[AW] != wr_ptr[AW])
                && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
  assign ll_ready = ~full;
  assign ll_acc  = ll_valid & ~full;
  assign alu_sel = alu_valid & (alu_waddr != 5'd0);
  assign pop     = ~alu_sel & ~empty;
  // Bypass the FIFO only when it is empty, which keeps ll results in order.
  assign direct  = ~alu_sel & empty & ll_acc;
  assign push    = ll_acc & (ll_waddr != 5'd0) & ~direct;

  always_comb begin
    wren_d  = 1'b0;
    waddr_d = waddr;
    wdata_d = wdata;
    src_d   = 1'b0;
    unique case (1'b1)
      alu_sel: begin
        wren_d  = 1'b1;
        waddr_d = alu_waddr;
        wdata_d = alu_wdata;
      end
      pop: begin
        wren_d  = 1'b1;
        waddr_d = fifo_addr[rd_ptr[AW-1:0]];
        wdata_d = fifo_data[rd_ptr[AW-1:0]];
        src_d   = 1'b1;
      end
      direct: begin
        wren_d  = (ll_waddr != 5'd0);
        waddr_d = ll_waddr;
        wdata_d = ll_wdata;
        src_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // Issue is applied after retirement so a same-cycle set wins.
  always_comb begin
    pending_d = pending;
    if (wren && src_ll)
      pending_d[waddr] = 1'b0;
    if (ll_issue && (ll_issue_rd != 5'd0))
      pending_d[ll_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wren    <= 1'b0;
      waddr   <= 5'd0;
      wdata   <= 32'd0;
      src_ll  <= 1'b0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      pending <= 32'd0;
    end else begin
      wren    <= wren_d;
      waddr   <= waddr_d;
      wdata   <= wdata_d;
      src_ll  <= src_d;
      pending <= pending_d;
      if (pop)
        rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      if (push)
        wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr[AW-1:0]] <= ll_waddr;
      fifo_data[wr_ptr[AW-1:0]] <= ll_wdata;
    end
  end

  assign hazard1   = pending[raddr1] & (raddr1 != 5'd0);
  assign hazard2   = pending[raddr2] & (raddr2 != 5'd0);
  assign fwd1      = wren & (waddr == raddr1) & (raddr1 != 5'd0);
  assign fwd2      = wren & (waddr == raddr2) & (raddr2 != 5'd0);
  assign fwd_data1 = wdata;
  assign fwd_data2 = wdata;
  assign busy      = ~empty | (|pending);

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios plus a randomized run
// against a queue-based model of the write port and scoreboard.
module tb_writeback_unit;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_waddr;
  logic [31:0] alu_wdata;
  logic        ll_issue;
  logic [4:0]  ll_issue_rd;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_waddr;
  logic [31:0] ll_wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        hazard1;
  logic        hazard2;
  logic        fwd1;
  logic        fwd2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
  logic        wren;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic [31:0] pend;
  logic        m_wren;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic        m_src;

  writeback_unit #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .ll_issue(ll_issue), .ll_issue_rd(ll_issue_rd),
    .ll_valid(ll_valid), .ll_ready(ll_ready),
    .ll_waddr(ll_waddr), .ll_wdata(ll_wdata),
    .raddr1(raddr1), .raddr2(raddr2),
    .hazard1(hazard1), .hazard2(hazard2),
    .fwd1(fwd1), .fwd2(fwd2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .wren(wren), .waddr(waddr), .wdata(wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic idle();
    alu_valid = 0; alu_waddr = 0; alu_wdata = 0;
    ll_issue = 0; ll_issue_rd = 0;
    ll_valid = 0; ll_waddr = 0; ll_wdata = 0;
  endtask

  task automatic model_reset();
    q.delete();
    pend = 0;
    m_wren = 0; m_waddr = 0; m_wdata = 0; m_src = 0;
  endtask

  // One clock edge; the model advances from the inputs present at the edge.
  task automatic step();
    logic        acc, took, nw, ns;
    logic [4:0]  na;
    logic [31:0] nd, np;
    ent_t        e;
    acc = ll_valid && (q.size() < D);
    took = 0; nw = 0; ns = 0; na = m_waddr; nd = m_wdata;
    if (alu_valid && alu_waddr != 0) begin
      nw = 1; na = alu_waddr; nd = alu_wdata;
    end else if (q.size() != 0) begin
      e = q.pop_front();
      nw = 1; ns = 1; na = e.a; nd = e.d;
    end else if (acc && ll_waddr != 0) begin
      nw = 1; ns = 1; na = ll_waddr; nd = ll_wdata; took = 1;
    end
    if (acc && ll_waddr != 0 && !took) begin
      e.a = ll_waddr; e.d = ll_wdata;
      q.push_back(e);
    end
    np = pend;
    if (m_wren && m_src) np[m_waddr] = 0;
    if (ll_issue && ll_issue_rd != 0) np[ll_issue_rd] = 1;
    @(posedge clk);
    #1;
    pend = np;
    m_wren = nw; m_waddr = na; m_wdata = nd; m_src = ns;
  endtask

  task automatic do_reset();
    idle();
    raddr1 = 0; raddr2 = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (wren !== 1'b0) begin n_fail++;
      $display("FAIL reset_wren got %b want 0", wren); end
    n_checks++; if (waddr !== 5'd0 || wdata !== 32'd0) begin n_fail++;
      $display("FAIL reset_port got %0d/%h want 0/0", waddr, wdata); end
    n_checks++; if (ll_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_ready got %b want 1", ll_ready); end
    n_checks++; if ({hazard1, hazard2, fwd1, fwd2} !== 4'b0) begin n_fail++;
      $display("FAIL reset_hz_fwd got %b want 0000",
               {hazard1, hazard2, fwd1, fwd2}); end
    n_checks++; if (fwd_data1 !== 32'd0 || fwd_data2 !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_fwd_data got %h/%h want 0", fwd_data1, fwd_data2);
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++;
      $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_ll_basic();
    ll_issue = 1; ll_issue_rd = 5;
    step();
    idle(); raddr1 = 5;
    #1;
    n_checks++; if (hazard1 !== 1'b1 || busy !== 1'b1) begin n_fail++;
      $display("FAIL ll_issue_hz got %b/%b want 1/1", hazard1, busy); end
    ll_valid = 1; ll_waddr = 5; ll_wdata = 32'hDEADBEEF;
    #1;
    n_checks++; if (ll_ready !== 1'b1) begin n_fail++;
      $display("FAIL ll_ready_empty got %b want 1", ll_ready); end
    step();
    idle();
    #1;
    n_checks++; if (wren !== 1 || waddr !== 5 || wdata !== 32'hDEADBEEF)
    begin n_fail++;
      $display("FAIL ll_direct got %b/%0d/%h want 1/5/deadbeef",
               wren, waddr, wdata); end
    n_checks++; if (fwd1 !== 1 || fwd_data1 !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL ll_fwd got %b/%h want 1/deadbeef", fwd1, fwd_data1);
    end
    step();
    #1;
    n_checks++; if (hazard1 !== 0 || busy !== 0 || wren !== 0) begin
      n_fail++;
      $display("FAIL ll_clear got hz%b busy%b wren%b want 000",
               hazard1, busy, wren); end
  endtask

  task automatic test_alu_vs_ll();
    ll_issue = 1; ll_issue_rd = 7;
    step();
    idle();
    alu_valid = 1; alu_waddr = 3; alu_wdata = 32'h11;
    ll_valid = 1; ll_waddr = 7; ll_wdata = 32'h22;
    step();
    idle();
    #1;
    n_checks++; if (wren !== 1 || waddr !== 3 || wdata !== 32'h11) begin
      n_fail++;
      $display("FAIL alu_first got %b/%0d/%h want 1/3/11",
               wren, waddr, wdata); end
    step();
    #1;
    n_checks++; if (wren !== 1 || waddr !== 7 || wdata !== 32'h22) begin
      n_fail++;
      $display("FAIL ll_second got %b/%0d/%h want 1/7/22",
               wren, waddr, wdata); end
    step();
  endtask

  task automatic test_fifo_full();
    ll_issue = 1; ll_issue_rd = 8; step();
    ll_issue_rd = 9; step();
    ll_issue_rd = 10; step();
    idle();
    alu_valid = 1; alu_waddr = 20; alu_wdata = 1;
    ll_valid = 1; ll_waddr = 8; ll_wdata = 32'hA;
    step();
    alu_wdata = 2; ll_waddr = 9; ll_wdata = 32'hB;
    step();
    alu_wdata = 3; ll_waddr = 10; ll_wdata = 32'hC;
    #1;
    n_checks++; if (ll_ready !== 1'b0) begin n_fail++;
      $display("FAIL fifo_full_ready got %b want 0", ll_ready); end
    step();
    #1;
    n_checks++; if (ll_ready !== 1'b0 || waddr !== 20 || wdata !== 3) begin
      n_fail++;
      $display("FAIL fifo_starve got rdy%b %0d/%h want 0 20/3",
               ll_ready, waddr, wdata); end
    alu_valid = 0;
    step();
    #1;
    n_checks++; if (wren !== 1 || waddr !== 8 || wdata !== 32'hA) begin
      n_fail++;
      $display("FAIL fifo_pop1 got %b/%0d/%h want 1/8/a", wren, waddr, wdata);
    end
    n_checks++; if (ll_ready !== 1'b1) begin n_fail++;
      $display("FAIL fifo_ready_back got %b want 1", ll_ready); end
    step();
    ll_valid = 0;
    #1;
    n_checks++; if (wren !== 1 || waddr !== 9 || wdata !== 32'hB) begin
      n_fail++;
      $display("FAIL fifo_pop2 got %b/%0d/%h want 1/9/b", wren, waddr, wdata);
    end
    step();
    #1;
    n_checks++; if (wren !== 1 || waddr !== 10 || wdata !== 32'hC) begin
      n_fail++;
      $display("FAIL fifo_pop3 got %b/%0d/%h want 1/10/c",
               wren, waddr, wdata); end
    idle();
    step();
  endtask

  task automatic test_x0();
    ll_issue = 1; ll_issue_rd = 4; step();
    idle();
    alu_valid = 1; alu_waddr = 0; alu_wdata = 32'h99;
    ll_valid = 1; ll_waddr = 4; ll_wdata = 32'h44;
    raddr1 = 0;
    step();
    idle();
    #1;
    n_checks++; if (wren !== 1 || waddr !== 4 || wdata !== 32'h44) begin
      n_fail++;
      $display("FAIL x0_direct got %b/%0d/%h want 1/4/44",
               wren, waddr, wdata); end
    n_checks++; if (fwd1 !== 0 || hazard1 !== 0) begin n_fail++;
      $display("FAIL x0_read got fwd%b hz%b want 00", fwd1, hazard1); end
    step();
  endtask

  task automatic test_set_wins();
    ll_issue = 1; ll_issue_rd = 6; step();
    idle();
    ll_valid = 1; ll_waddr = 6; ll_wdata = 32'h66;
    step();
    idle();
    ll_issue = 1; ll_issue_rd = 6; raddr2 = 6;
    step();
    idle();
    #1;
    n_checks++; if (hazard2 !== 1'b1) begin n_fail++;
      $display("FAIL set_wins got %b want 1", hazard2); end
    ll_valid = 1; ll_waddr = 6; ll_wdata = 32'h67;
    step();
    idle();
    repeat (2) step();
    raddr2 = 0;
  endtask

  task automatic test_reset_mid();
    ll_issue = 1; ll_issue_rd = 11; step();
    ll_issue_rd = 12; step();
    idle();
    alu_valid = 1; alu_waddr = 21; alu_wdata = 5;
    ll_valid = 1; ll_waddr = 11; ll_wdata = 32'hB1;
    step();
    ll_waddr = 12; ll_wdata = 32'hB2;
    step();
    #2;
    rst = 1;
    #1;
    n_checks++; if (wren !== 0 || ll_ready !== 1 || busy !== 0) begin
      n_fail++;
      $display("FAIL reset_mid got wren%b rdy%b busy%b want 010",
               wren, ll_ready, busy); end
    idle();
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (wren !== 1'b0) begin n_fail++;
        $display("FAIL reset_stale cyc%0d got wren %b waddr %0d want 0",
                 i, wren, waddr); end
    end
  endtask

  task automatic test_random();
    int issued[$];
    int k, r, tries;
    logic acc;
    for (int cyc = 0; cyc < 400; cyc++) begin
      idle();
      if ($urandom_range(1, 0) == 1) begin
        tries = 0;
        do begin
          r = $urandom_range(31, 0);
          tries++;
        end while (pend[r] && tries < 64);
        if (!pend[r]) begin
          alu_valid = 1; alu_waddr = 5'(r); alu_wdata = $urandom;
        end
      end
      if ($urandom_range(9, 0) < 3) begin
        tries = 0;
        do begin
          r = $urandom_range(31, 1);
          tries++;
        end while ((pend[r] || (alu_valid && alu_waddr == r)) && tries < 64);
        if (!pend[r] && !(alu_valid && alu_waddr == r)) begin
          ll_issue = 1; ll_issue_rd = 5'(r);
        end
      end
      if (issued.size() != 0 && $urandom_range(1, 0) == 1) begin
        k = $urandom_range(issued.size() - 1, 0);
        ll_valid = 1; ll_waddr = 5'(issued[k]); ll_wdata = $urandom;
      end else if ($urandom_range(19, 0) == 0) begin
        k = -1;
        ll_valid = 1; ll_waddr = 0; ll_wdata = $urandom;
      end else begin
        k = -1;
      end
      raddr1 = $urandom; raddr2 = $urandom;
      #1;
      n_checks++; if (ll_ready !== (q.size() < D)) begin n_fail++;
        $display("FAIL rnd_ready cyc%0d got %b want %b",
                 cyc, ll_ready, q.size() < D); end
      n_checks++;
      if (hazard1 !== (pend[raddr1] && raddr1 != 0) ||
          hazard2 !== (pend[raddr2] && raddr2 != 0)) begin n_fail++;
        $display("FAIL rnd_hazard cyc%0d got %b%b want %b%b", cyc,
                 hazard1, hazard2, pend[raddr1] && raddr1 != 0,
                 pend[raddr2] && raddr2 != 0); end
      n_checks++;
      if (fwd1 !== (m_wren && m_waddr == raddr1 && raddr1 != 0) ||
          fwd2 !== (m_wren && m_waddr == raddr2 && raddr2 != 0)) begin
        n_fail++;
        $display("FAIL rnd_fwd cyc%0d got %b%b", cyc, fwd1, fwd2); end
      if (m_wren) begin
        n_checks++;
        if (fwd_data1 !== m_wdata || fwd_data2 !== m_wdata) begin n_fail++;
          $display("FAIL rnd_fwd_data cyc%0d got %h/%h want %h",
                   cyc, fwd_data1, fwd_data2, m_wdata); end
      end
      acc = ll_valid && (q.size() < D);
      if (acc && k >= 0) issued.delete(k);
      if (ll_issue) issued.push_back(int'(ll_issue_rd));
      step();
      n_checks++; if (wren !== m_wren || busy !== (q.size() != 0 || pend != 0))
      begin n_fail++;
        $display("FAIL rnd_wren_busy cyc%0d got %b%b want %b%b", cyc,
                 wren, busy, m_wren, q.size() != 0 || pend != 0); end
      if (m_wren) begin
        n_checks++;
        if (waddr !== m_waddr || wdata !== m_wdata || waddr == 0) begin
          n_fail++;
          $display("FAIL rnd_write cyc%0d got %0d/%h want %0d/%h",
                   cyc, waddr, wdata, m_waddr, m_wdata); end
      end
    end
    for (int i = 0; i < 200 && issued.size() != 0; i++) begin
      idle();
      ll_valid = 1; ll_waddr = 5'(issued[0]); ll_wdata = $urandom;
      if (q.size() < D) void'(issued.pop_front());
      step();
    end
    idle();
    repeat (D + 3) step();
    n_checks++; if (busy !== 1'b0 || wren !== 1'b0) begin n_fail++;
      $display("FAIL rnd_drain got busy%b wren%b want 00", busy, wren); end
  endtask

  initial begin
    idle();
    raddr1 = 0; raddr2 = 0;
    rst = 1;
    model_reset();
    test_reset();
    test_ll_basic();
    test_alu_vs_ll();
    test_fifo_full();
    test_x0();
    test_set_wins();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
